// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle spawn scheduler.
package obstacle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GAP = 2'd1,
        ST_SPAWN    = 2'd2,
        ST_FROZEN   = 2'd3
    } sched_state_t;

    localparam logic KIND_SMALL = 1'b0;
    localparam logic KIND_BIG   = 1'b1;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int SPEEDUP_STEP  = 8;
    localparam int SPEEDUP_SHIFT = 3;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// Purpose: 16-bit Fibonacci LFSR with hold enable, reset to SEED.
// Latency: new value visible the cycle after each enabled clock.
// Backpressure: none; en low simply holds the current value.
module obstacle_lfsr
    import obstacle_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Purpose: spawn scheduler for cactus sprites; optional OBSTACLE_SPEEDUP_EN shrinks the gap.
// Latency: start pulse two cycles after the terminal scroll_tick when a slot is free.
// Backpressure: stalls in SPAWN without pulsing until a sprite slot is free and unclaimed.
module obstacle_scheduler
    import obstacle_pkg::*;
#(
    parameter int          NUM_SLOTS      = 2,
    parameter int          MIN_GAP        = 160,
    parameter int          GAP_RANGE_BITS = 7,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 scroll_tick,
    input  logic                 run,
    input  logic                 game_over,
    input  logic [NUM_SLOTS-1:0] slot_finish,
    output logic [NUM_SLOTS-1:0] slot_start,
    output logic [NUM_SLOTS-1:0] slot_kind,
    output logic [7:0]           spawn_count,
    output logic [1:0]           sched_state
);

    if (MIN_GAP < 1 || MIN_GAP + (1 << GAP_RANGE_BITS) - 1 > 65535) begin : g_gap_overflow
        $error("obstacle_scheduler: MIN_GAP plus random extra gap exceeds 16 bits");
    end

    sched_state_t         state;
    logic [15:0]          gap_cnt;
    logic [NUM_SLOTS-1:0] claimed;
    logic [NUM_SLOTS-1:0] fin_prev;
    logic [15:0]          lfsr;
    logic                 lfsr_unused;

    logic [NUM_SLOTS-1:0] eligible;
    logic [NUM_SLOTS-1:0] pick;
    logic [NUM_SLOTS-1:0] fin_rise;
    logic [7:0]           count_next;
    logic [15:0]          eff_min;
    logic [15:0]          gap_load;
    logic                 new_kind;

    obstacle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .en   (state != ST_FROZEN),
        .lfsr (lfsr)
    );

    assign lfsr_unused = ^lfsr;

    // Lowest-index eligible slot wins: isolate the least significant set bit
    assign eligible   = slot_finish & ~claimed;
    assign pick       = eligible & (~eligible + NUM_SLOTS'(1));
    assign fin_rise   = slot_finish & ~fin_prev;
    assign count_next = (spawn_count == 8'hFF) ? spawn_count : spawn_count + 8'd1;
    assign new_kind   = lfsr[15] ? KIND_BIG : KIND_SMALL;

`ifdef OBSTACLE_SPEEDUP_EN
    logic [15:0] gap_cut;
    assign gap_cut = 16'(SPEEDUP_STEP) * 16'(count_next >> SPEEDUP_SHIFT);
    assign eff_min = (16'(MIN_GAP) > gap_cut + 16'(MIN_GAP / 2)) ? 16'(MIN_GAP) - gap_cut
                                                                  : 16'(MIN_GAP / 2);
`else
    assign eff_min = 16'(MIN_GAP);
`endif

    assign gap_load    = eff_min + 16'(lfsr[GAP_RANGE_BITS-1:0]);
    assign sched_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            claimed     <= '0;
            fin_prev    <= '0;
            slot_start  <= '0;
            slot_kind   <= '0;
            spawn_count <= '0;
        end else begin
            fin_prev   <= slot_finish;
            slot_start <= '0;
            if (!run) begin
                state       <= ST_IDLE;
                gap_cnt     <= '0;
                claimed     <= '0;
                spawn_count <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_WAIT_GAP;
                        gap_cnt <= gap_load;
                        claimed <= '0;
                    end
                    ST_WAIT_GAP: begin
                        claimed <= claimed & ~fin_rise;
                        if (game_over) begin
                            state <= ST_FROZEN;
                        // a tick landing on the start pulse belongs to the old gap
                        end else if (scroll_tick && slot_start == '0) begin
                            if (gap_cnt <= 16'd1) begin
                                gap_cnt <= '0;
                                state   <= ST_SPAWN;
                            end else begin
                                gap_cnt <= gap_cnt - 16'd1;
                            end
                        end
                    end
                    ST_SPAWN: begin
                        if (game_over) begin
                            state <= ST_FROZEN;
                        end else begin
                            claimed <= (claimed & ~fin_rise) | pick;
                            if (pick != '0) begin
                                slot_start  <= pick;
                                slot_kind   <= (slot_kind & ~pick) | (pick & {NUM_SLOTS{new_kind}});
                                spawn_count <= count_next;
                                gap_cnt     <= gap_load;
                                state       <= ST_WAIT_GAP;
                            end
                        end
                    end
                    ST_FROZEN: begin
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scenario bench for obstacle_scheduler with a pulse scoreboard and an independent LFSR model.
`timescale 1ns/1ps
module tb_obstacle_scheduler;

    localparam int          NS   = 2;
    localparam int          MG   = 4;
    localparam int          GRB  = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          scroll_tick = 1'b0;
    logic          run = 1'b0;
    logic          game_over = 1'b0;
    logic [NS-1:0] slot_finish = 2'b11;
    logic [NS-1:0] slot_start;
    logic [NS-1:0] slot_kind;
    logic [7:0]    spawn_count;
    logic [1:0]    sched_state;

    int checks = 0;
    int errors = 0;

    logic [NS-1:0] exp_q[$];
    logic [NS-1:0] exp_kind = '0;
    logic [15:0]   m_lfsr;
    logic [15:0]   m_prev;
    bit            m_frozen = 1'b0;
    int            last_gap = MG;
    int            exp_count = 0;

    always #5 clk = ~clk;

    obstacle_scheduler #(
        .NUM_SLOTS(NS), .MIN_GAP(MG), .GAP_RANGE_BITS(GRB), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rstn(rstn), .scroll_tick(scroll_tick), .run(run), .game_over(game_over),
        .slot_finish(slot_finish), .slot_start(slot_start), .slot_kind(slot_kind),
        .spawn_count(spawn_count), .sched_state(sched_state)
    );

    function automatic logic [15:0] model_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // m_prev holds the LFSR value the DUT saw at the most recent rising edge
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_lfsr <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_lfsr;
            if (!m_frozen) m_lfsr <= model_step(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (rstn && slot_start != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got %b expected none", slot_start);
            end else begin
                logic [NS-1:0] e;
                e = exp_q.pop_front();
                if (slot_start !== e) begin
                    errors++;
                    $display("FAIL pulse_slot got %b expected %b", slot_start, e);
                end
                for (int i = 0; i < NS; i++) if (e[i]) exp_kind[i] = m_prev[15];
                checks++;
                if (slot_kind !== exp_kind) begin
                    errors++;
                    $display("FAIL slot_kind got %b expected %b", slot_kind, exp_kind);
                end
            end
            exp_count = (exp_count == 255) ? 255 : exp_count + 1;
            last_gap  = MG + int'(m_prev[GRB-1:0]);
        end
    end

    task automatic tick();
        @(negedge clk) scroll_tick = 1'b1;
        @(negedge clk) scroll_tick = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clk);
        last_gap = MG + int'(m_lfsr[GRB-1:0]);
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (sched_state !== 2'd1) begin
            errors++;
            $display("FAIL start_state got %0d expected 1", sched_state);
        end
    endtask

    task automatic run_gap(input logic [NS-1:0] expv);
        int g;
        bit seen;
        g = last_gap;
        seen = 1'b0;
        exp_q.push_back(expv);
        @(negedge clk);
        repeat (g - 1) tick();
        repeat (2) @(negedge clk);
        checks++;
        if (sched_state !== 2'd1) begin
            errors++;
            $display("FAIL gap_early got state %0d expected 1 after %0d of %0d ticks", sched_state, g - 1, g);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (slot_start != '0) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL pulse_timeout got none expected %b", expv);
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (slot_start !== '0) begin
            errors++;
            $display("FAIL pulse_width got %b expected 00", slot_start);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (slot_start !== '0 || slot_kind !== '0 || spawn_count !== 8'd0 || sched_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs got start=%b kind=%b cnt=%0d st=%0d expected 0 0 0 0",
                     slot_start, slot_kind, spawn_count, sched_state);
        end
        checks++;
        if (dut.u_lfsr.lfsr !== SEED) begin
            errors++;
            $display("FAIL reset_lfsr got %h expected %h", dut.u_lfsr.lfsr, SEED);
        end
        @(negedge clk) rstn = 1'b1;
    endtask

    task automatic test_first_spawn();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (m_lfsr[GRB-1:0] == '0) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL seed_search got none expected extra=0 within 64 cycles");
        end
        run = 1'b1;
        last_gap = MG;
        exp_q.push_back(2'b01);
        @(negedge clk);
        checks++;
        if (sched_state !== 2'd1) begin
            errors++;
            $display("FAIL first_wait got %0d expected 1", sched_state);
        end
        repeat (MG - 1) tick();
        @(negedge clk) scroll_tick = 1'b1;
        @(negedge clk) scroll_tick = 1'b0;
        checks++;
        if (sched_state !== 2'd2 || slot_start !== '0) begin
            errors++;
            $display("FAIL first_spawn_state got st=%0d start=%b expected 2 00", sched_state, slot_start);
        end
        @(negedge clk);
        checks++;
        if (slot_start !== 2'b01 || spawn_count !== 8'd1) begin
            errors++;
            $display("FAIL first_pulse got start=%b cnt=%0d expected 01 1", slot_start, spawn_count);
        end
        @(negedge clk);
        checks++;
        if (slot_start !== '0) begin
            errors++;
            $display("FAIL first_width got %b expected 00", slot_start);
        end
    endtask

    task automatic test_stall();
        @(negedge clk) slot_finish = 2'b00;
        repeat (last_gap) tick();
        repeat (4) @(negedge clk);
        checks++;
        if (sched_state !== 2'd2 || slot_start !== '0) begin
            errors++;
            $display("FAIL stall got st=%0d start=%b expected 2 00", sched_state, slot_start);
        end
        exp_q.push_back(2'b10);
        slot_finish = 2'b10;
        @(negedge clk);
        checks++;
        if (slot_start !== 2'b10) begin
            errors++;
            $display("FAIL stall_release got %b expected 10", slot_start);
        end
        scroll_tick = 1'b1;
        @(negedge clk) scroll_tick = 1'b0;
        checks++;
        if (sched_state !== 2'd1 || spawn_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL stall_after got st=%0d cnt=%0d expected 1 %0d", sched_state, spawn_count, exp_count);
        end
    endtask

    task automatic test_engine_lag();
        @(negedge clk) slot_finish = 2'b00;
        @(negedge clk) slot_finish = 2'b11;
        run_gap(2'b01);
        run_gap(2'b10);
        @(negedge clk) slot_finish = 2'b10;
        @(negedge clk) slot_finish = 2'b11;
        run_gap(2'b01);
        checks++;
        if (spawn_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL lag_count got %0d expected %0d", spawn_count, exp_count);
        end
    endtask

    task automatic test_frozen();
        repeat (last_gap - 2) tick();
        @(negedge clk) game_over = 1'b1;
        @(negedge clk) m_frozen = 1'b1;
        checks++;
        if (sched_state !== 2'd3) begin
            errors++;
            $display("FAIL frozen_enter got %0d expected 3", sched_state);
        end
        repeat (10) tick();
        repeat (3) @(negedge clk);
        checks++;
        if (sched_state !== 2'd3 || slot_start !== '0) begin
            errors++;
            $display("FAIL frozen_hold got st=%0d start=%b expected 3 00", sched_state, slot_start);
        end
        checks++;
        if (dut.u_lfsr.lfsr !== m_lfsr) begin
            errors++;
            $display("FAIL frozen_lfsr got %h expected %h", dut.u_lfsr.lfsr, m_lfsr);
        end
        run = 1'b0;
        game_over = 1'b0;
        @(negedge clk) m_frozen = 1'b0;
        exp_count = 0;
        checks++;
        if (sched_state !== 2'd0 || spawn_count !== 8'd0) begin
            errors++;
            $display("FAIL frozen_exit got st=%0d cnt=%0d expected 0 0", sched_state, spawn_count);
        end
    endtask

    task automatic test_gameover_terminal();
        start_run();
        repeat (last_gap - 1) tick();
        @(negedge clk);
        scroll_tick = 1'b1;
        game_over = 1'b1;
        @(negedge clk);
        scroll_tick = 1'b0;
        m_frozen = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (sched_state !== 2'd3 || spawn_count !== 8'd0) begin
            errors++;
            $display("FAIL go_terminal got st=%0d cnt=%0d expected 3 0", sched_state, spawn_count);
        end
        run = 1'b0;
        game_over = 1'b0;
        @(negedge clk) m_frozen = 1'b0;
    endtask

    task automatic test_reset_midpulse();
        start_run();
        repeat (last_gap) tick();
        checks++;
        if (sched_state !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_state got %0d expected 2", sched_state);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (slot_start !== '0 || sched_state !== 2'd0 || spawn_count !== 8'd0 || slot_kind !== '0) begin
            errors++;
            $display("FAIL async_reset got start=%b st=%0d cnt=%0d kind=%b expected 00 0 0 00",
                     slot_start, sched_state, spawn_count, slot_kind);
        end
        checks++;
        if (dut.u_lfsr.lfsr !== SEED) begin
            errors++;
            $display("FAIL async_reset_lfsr got %h expected %h", dut.u_lfsr.lfsr, SEED);
        end
        exp_kind = '0;
        exp_count = 0;
        @(negedge clk);
        checks++;
        if (slot_start !== '0) begin
            errors++;
            $display("FAIL dropped_pulse got %b expected 00", slot_start);
        end
        run = 1'b0;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_stall();
        test_engine_lag();
        test_frozen();
        test_gameover_terminal();
        test_reset_midpulse();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Spawn scheduler for the runner game's obstacle sprites. Decides when the next cactus enters from the right edge, picks a free sprite slot and its kind (small/big), and issues a one-cycle start pulse to that slot. Sits between the game-state logic (run/collision) and the bank of cactus sprite engines, whose `finish` flags it monitors to track slot occupancy.

## Interface
- `NUM_SLOTS`, 2: number of sprite engine slots (1..4).
- `MIN_GAP`, 160: minimum scroll ticks between spawns (≥1).
- `GAP_RANGE_BITS`, 7: random extra gap width; extra = 0..2^GAP_RANGE_BITS−1.
- `LFSR_SEED`, 16'hACE1: LFSR reset value (nonzero).

- `clk` in 1: system clock, the only clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `scroll_tick` in 1: one-cycle pulse per one-column scroll step.
- `run` in 1: game running level; low returns block to IDLE.
- `game_over` in 1: collision level; freezes scheduling.
- `slot_finish` in NUM_SLOTS: per-slot finish flag from sprite engines (1 = off-screen/free).
- `slot_start` out NUM_SLOTS: one-hot, one-cycle start pulse to a slot.
- `slot_kind` out NUM_SLOTS: per-slot latched kind, 0 small, 1 big.
- `spawn_count` out 8: obstacles spawned since leaving IDLE, saturates at 255.
- `sched_state` out 2: current state encoding for debug/score logic.

## Operation
- States: IDLE=0, WAIT_GAP=1, SPAWN=2, FROZEN=3.
- IDLE: gap counter, `claimed`, `spawn_count` cleared; `run`=1 → WAIT_GAP, gap counter loaded with `MIN_GAP + lfsr[GAP_RANGE_BITS-1:0]`.
- WAIT_GAP: counter decrements on each `scroll_tick`; the tick that takes it 1→0 moves to SPAWN. A gap value G therefore spans exactly G ticks.
- SPAWN: eligible slot = `slot_finish[i]`=1 and `claimed[i]`=0; lowest index wins. If none eligible, stay in SPAWN (stall, no pulse). If eligible: pulse `slot_start[i]`, set `claimed[i]`, latch `slot_kind[i]` = `lfsr[15]`, increment `spawn_count` (saturating), reload gap counter, → WAIT_GAP.
- `claimed[i]` clears on a 0→1 edge of `slot_finish[i]` (registered previous value); it guards against the engine's `finish` not yet dropping after start.
- `game_over`=1 in WAIT_GAP or SPAWN → FROZEN: no pulses, counter and `claimed` held. FROZEN exits only via `run`=0 → IDLE.
- `run`=0 in any state → IDLE next cycle (overrides `game_over`).
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every clock except in FROZEN; never all-zero.
- Gap arithmetic: 16-bit unsigned; `MIN_GAP + extra` must not overflow (checked by elaboration-time assertion).

## Timing
- Reset values: `slot_start`=0, `slot_kind`=0, `spawn_count`=0, `sched_state`=IDLE; LFSR = `LFSR_SEED`.
- All outputs registered. `slot_start` high exactly one cycle, in the cycle after the SPAWN-state clock edge that sees an eligible slot.
- `slot_kind[i]` valid in the same cycle as `slot_start[i]` and held until the next spawn to slot i.
- Entry to SPAWN is one cycle after the terminal `scroll_tick`; with a free slot, pulse appears two cycles after that tick.
- `scroll_tick` coincident with the spawn pulse is not counted against the new gap.
- `game_over` and terminal `scroll_tick` in same cycle: FROZEN wins, no spawn.
- Slot freeing (`slot_finish` 0→1) and spawn to same slot in same cycle: slot is not eligible until the following cycle.
- Reset asserted mid-operation: all state returns to reset values immediately (async), pending pulse dropped.

## Configuration
- `OBSTACLE_SPEEDUP_EN` defined: effective minimum gap = `MIN_GAP − 8·(spawn_count>>3)`, floored at `MIN_GAP/2` (integer), recomputed at each reload.
- Not defined: effective minimum gap is constantly `MIN_GAP`; no extra logic.

## Structure
- `obstacle_pkg`: state enum, kind encoding (KIND_SMALL/KIND_BIG), LFSR tap mask, speed-up step (8) and shift (3) constants.
- Sub-module `obstacle_lfsr`: 16-bit LFSR with enable and seed parameter; everything else in the top.

## Test plan
- MIN_GAP=4, GAP_RANGE_BITS=2, seed forcing extra=0: `run`↑, 4 `scroll_tick`s → `slot_start`=2'b01 one cycle, two cycles after the 4th tick; `spawn_count`=1.
- Both slots busy (`slot_finish`=00) at gap expiry → state stays SPAWN, no pulse; raise `slot_finish[1]` → `slot_start`=2'b10 next cycle.
- After a spawn to slot 0, hold `slot_finish[0]`=1 (engine lag) → next spawn goes to slot 1, not slot 0; drop and re-raise `slot_finish[0]` → slot 0 eligible again.
- `game_over`=1 during WAIT_GAP with 2 ticks left → FROZEN, 10 further ticks give no pulse; `run`=0 → IDLE, `spawn_count`=0.
- `rstn` low in the cycle a pulse is due → `slot_start` stays 0, LFSR = seed, state IDLE.
- With `OBSTACLE_SPEEDUP_EN`, MIN_GAP=32: after 8 spawns reload uses 24; after 32 spawns floored at 16.
